id_stage: RTL
=============

Name: id_stage

Overview:
Instruction decode stage of the 5-stage pipeline, directly downstream of instruction fetch. It has four jobs:
- Latch the fetched instruction and PC into the IF/ID register.
- Decode fields and control, and read the 32x64 register file (with write-back bypass).
- Detect load-use hazards against the instruction it is handing to EX.
- Drive the ID/EX pipeline register.
It back-pressures fetch via stall_if, which holds the PC.

Parameters:
DATA_W, 64, register/datapath width
PC_W, 8, program counter width (256-entry instruction memory)
NREG, 32, register file depth (5-bit register indices)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
if_pc  in  PC_W  PC of fetched instruction
if_instr  in  32  fetched instruction word
if_valid  in  1  if_pc/if_instr valid this cycle
flush  in  1  squash IF/ID and ID/EX contents (taken branch)
wb_we  in  1  write-back enable
wb_rd  in  5  write-back destination
wb_data  in  DATA_W  write-back value
stall_if  out  1  hold PC/fetch this cycle (combinational)
id_valid  out  1  ID/EX entry valid
id_pc  out  PC_W  PC of ID/EX instruction
id_opcode  out  6  opcode
id_rd, id_rs1, id_rs2  out  5 each  register indices
id_rs1_data, id_rs2_data  out  DATA_W each  operand values
id_imm  out  DATA_W  sign-extended instr[15:0]
id_reg_we, id_mem_read, id_mem_write, id_branch  out  1 each  control bits
id_illegal  out  1  undefined opcode decoded

Behaviour:
- Encoding:
  - Fields: [31:26] opcode, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm.
  - 0x00 NOP: no control bits set.
  - 0x01 ADD, 0x02 SUB: reg_we, uses rs1 and rs2.
  - 0x03 ADDI: reg_we, uses rs1.
  - 0x04 LD: reg_we + mem_read, uses rs1.
  - 0x05 SD: mem_write, uses rs1 and rs2.
  - 0x06 BEQ: branch, uses rs1 and rs2.
  - Any other opcode: id_illegal=1, all control bits 0, valid kept.
- reg_we is forced to 0 when rd==0.
- Register file:
  - 32 x DATA_W. Written on the clk edge when wb_we && wb_rd!=0.
  - r0 always reads 0.
  - Read bypass: if wb_we && wb_rd!=0 && wb_rd==rsN, the read returns wb_data in the same cycle.
- IF/ID register: loads {if_valid, if_pc, if_instr} each edge unless stall_if. Under stall_if it holds.
- ID/EX register: loads the decoded IF/ID contents each edge. All id_* outputs are registered.
- Latency: an instruction presented with if_valid at edge N appears on id_* after edge N+1 (2 edges), absent stalls.
- Load-use hazard:
  - stall_if = IF/ID valid && id_valid && id_mem_read && id_rd!=0 && (id_rd==rs1 || (uses_rs2 && id_rd==rs2)).
  - On stall: IF/ID holds, and ID/EX loads a bubble (id_valid=0, all control bits 0).
  - The stall lasts exactly one cycle, because the bubble clears id_mem_read.
- Flush:
  - At the next edge, IF/ID valid=0 and ID/EX is a bubble.
  - Flush has priority over stall; stall_if=0 whenever flush=1.
- Bubble/invalid entries: id_valid=0 and all control bits 0. Data fields are don't-care but must be deterministic; bubbles load 0.
- Reset (synchronous):
  - IF/ID and ID/EX are cleared; every id_* output is 0 and stall_if is 0.
  - All register file entries are 0.
  - Reset wins over flush, stall and wb_we in the same cycle.
  - Reset mid-stall discards the held instruction.
- Write-back and decode of the same register in the same cycle returns the new value. Writes to r0 are ignored.

Test Plan:
1. Reset, then ADDI rd=1 rs1=0 imm=0xFFFF at pc=0x05 -> two edges later: id_valid=1, id_pc=0x05, id_imm=0xFFFF_FFFF_FFFF_FFFF, id_reg_we=1, id_rs1_data=0.
2. Write-back r3=0x1234 while ADD rd=4 rs1=3 rs2=3 is in IF/ID -> id_rs1_data=id_rs2_data=0x1234 (bypass). A write to r0 of 0xDEAD leaves r0 reading 0.
3. LD rd=2 followed by ADD rs1=2 -> stall_if=1 for exactly one cycle, one bubble (id_valid=0), then ADD is issued. LD rd=2 followed by ADDI rs1=5 -> no stall.
4. flush asserted during a load-use stall -> stall_if=0, next cycle id_valid=0, and IF/ID is invalid.
5. Opcode 0x3F -> id_illegal=1, all control bits 0. rst asserted mid-stream -> all outputs 0 after one edge, and the register file reads 0.
6. SD rs1=1 rs2=2 after LD rd=2 -> stall (uses rs2). BEQ after LD rd=0 -> no stall.

Source files
------------

// File: rtl/id_stage_if.sv
// Bundle of fetch, flush, write-back and ID/EX signals around the decode stage.
// The master side (fetch/EX/WB environment) drives the stage inputs; the slave is id_stage.
interface id_stage_if #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 8
);
    logic [PC_W-1:0]   if_pc;
    logic [31:0]       if_instr;
    logic              if_valid;
    logic              flush;
    logic              wb_we;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              stall_if;
    logic              id_valid;
    logic [PC_W-1:0]   id_pc;
    logic [5:0]        id_opcode;
    logic [4:0]        id_rd;
    logic [4:0]        id_rs1;
    logic [4:0]        id_rs2;
    logic [DATA_W-1:0] id_rs1_data;
    logic [DATA_W-1:0] id_rs2_data;
    logic [DATA_W-1:0] id_imm;
    logic              id_reg_we;
    logic              id_mem_read;
    logic              id_mem_write;
    logic              id_branch;
    logic              id_illegal;

    modport master (
        output if_pc, if_instr, if_valid, flush, wb_we, wb_rd, wb_data,
        input  stall_if, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_reg_we, id_mem_read,
               id_mem_write, id_branch, id_illegal
    );

    modport slave (
        input  if_pc, if_instr, if_valid, flush, wb_we, wb_rd, wb_data,
        output stall_if, id_valid, id_pc, id_opcode, id_rd, id_rs1, id_rs2,
               id_rs1_data, id_rs2_data, id_imm, id_reg_we, id_mem_read,
               id_mem_write, id_branch, id_illegal
    );
endinterface

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, field/control decode, bypassed register file read,
// load-use hazard detection and the registered ID/EX pipeline entry.
module id_stage #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 8,
    parameter int NREG   = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_if.slave    bus
);
    logic              ifid_valid_r;
    logic [PC_W-1:0]   ifid_pc_r;
    logic [31:0]       ifid_instr_r;
    logic [DATA_W-1:0] rf_r [NREG];

    logic [5:0]        opcode_s;
    logic [4:0]        rd_s;
    logic [4:0]        rs1_s;
    logic [4:0]        rs2_s;
    logic [15:0]       imm16_s;
    logic [DATA_W-1:0] imm_s;
    logic              reg_we_s;
    logic              mem_read_s;
    logic              mem_write_s;
    logic              branch_s;
    logic              uses_rs2_s;
    logic              illegal_s;
    logic              wb_live_s;
    logic [DATA_W-1:0] rs1_data_s;
    logic [DATA_W-1:0] rs2_data_s;
    logic              hazard_s;
    logic              stall_s;
    logic              bubble_s;

    assign opcode_s = ifid_instr_r[31:26];
    assign rd_s     = ifid_instr_r[25:21];
    assign rs1_s    = ifid_instr_r[20:16];
    assign rs2_s    = ifid_instr_r[15:11];
    assign imm16_s  = ifid_instr_r[15:0];
    assign imm_s    = {{(DATA_W-16){imm16_s[15]}}, imm16_s};

    // Control decode of the IF/ID instruction; unknown opcodes raise illegal only.
    always_comb begin
        reg_we_s    = 1'b0;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        branch_s    = 1'b0;
        uses_rs2_s  = 1'b0;
        illegal_s   = 1'b0;
        case (opcode_s)
            6'h00: begin
                reg_we_s = 1'b0;
            end
            6'h01, 6'h02: begin
                reg_we_s   = 1'b1;
                uses_rs2_s = 1'b1;
            end
            6'h03: begin
                reg_we_s = 1'b1;
            end
            6'h04: begin
                reg_we_s   = 1'b1;
                mem_read_s = 1'b1;
            end
            6'h05: begin
                mem_write_s = 1'b1;
                uses_rs2_s  = 1'b1;
            end
            6'h06: begin
                branch_s   = 1'b1;
                uses_rs2_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    // A write-back to the register being read this cycle is forwarded directly.
    assign wb_live_s  = bus.wb_we && (bus.wb_rd != 5'd0);
    assign rs1_data_s = (rs1_s == 5'd0) ? {DATA_W{1'b0}} :
                        (wb_live_s && (bus.wb_rd == rs1_s)) ? bus.wb_data : rf_r[rs1_s];
    assign rs2_data_s = (rs2_s == 5'd0) ? {DATA_W{1'b0}} :
                        (wb_live_s && (bus.wb_rd == rs2_s)) ? bus.wb_data : rf_r[rs2_s];

    assign hazard_s = ifid_valid_r && bus.id_valid && bus.id_mem_read && (bus.id_rd != 5'd0) &&
                      ((bus.id_rd == rs1_s) || (uses_rs2_s && (bus.id_rd == rs2_s)));
    assign stall_s  = hazard_s && !bus.flush && !rst;
    assign bus.stall_if = stall_s;
    assign bubble_s = rst || bus.flush || stall_s || !ifid_valid_r;

    // Register file; reset clears every entry and r0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wb_live_s) begin
            rf_r[bus.wb_rd] <= bus.wb_data;
        end else begin
            rf_r[bus.wb_rd] <= rf_r[bus.wb_rd];
        end
    end

    // IF/ID latch: flush squashes, a load-use stall holds the current entry.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            ifid_valid_r <= 1'b0;
            ifid_pc_r    <= {PC_W{1'b0}};
            ifid_instr_r <= 32'd0;
        end else if (stall_s) begin
            ifid_valid_r <= ifid_valid_r;
            ifid_pc_r    <= ifid_pc_r;
            ifid_instr_r <= ifid_instr_r;
        end else begin
            ifid_valid_r <= bus.if_valid;
            ifid_pc_r    <= bus.if_pc;
            ifid_instr_r <= bus.if_instr;
        end
    end

    // ID/EX entry: a bubble is all-zero so downstream never sees stale data.
    always_ff @(posedge clk) begin
        if (bubble_s) begin
            bus.id_valid     <= 1'b0;
            bus.id_pc        <= {PC_W{1'b0}};
            bus.id_opcode    <= 6'd0;
            bus.id_rd        <= 5'd0;
            bus.id_rs1       <= 5'd0;
            bus.id_rs2       <= 5'd0;
            bus.id_rs1_data  <= {DATA_W{1'b0}};
            bus.id_rs2_data  <= {DATA_W{1'b0}};
            bus.id_imm       <= {DATA_W{1'b0}};
            bus.id_reg_we    <= 1'b0;
            bus.id_mem_read  <= 1'b0;
            bus.id_mem_write <= 1'b0;
            bus.id_branch    <= 1'b0;
            bus.id_illegal   <= 1'b0;
        end else begin
            bus.id_valid     <= 1'b1;
            bus.id_pc        <= ifid_pc_r;
            bus.id_opcode    <= opcode_s;
            bus.id_rd        <= rd_s;
            bus.id_rs1       <= rs1_s;
            bus.id_rs2       <= rs2_s;
            bus.id_rs1_data  <= rs1_data_s;
            bus.id_rs2_data  <= rs2_data_s;
            bus.id_imm       <= imm_s;
            bus.id_reg_we    <= reg_we_s && (rd_s != 5'd0);
            bus.id_mem_read  <= mem_read_s;
            bus.id_mem_write <= mem_write_s;
            bus.id_branch    <= branch_s;
            bus.id_illegal   <= illegal_s;
        end
    end
endmodule
